seven_seg_display_ctrl: RTL and testbench
=========================================

# seven_seg_display_ctrl

Registered, parametrised seven-segment display controller. It generalises the fixed six-digit, inverted-bus HEX0–HEX5 drive of the board top level to N digits. Features: per-digit hex decode or raw segments, timed blinking, and automatic rotate-scrolling. It sits between a processor-side parallel port, or any write source, and the board HEX pins.

## Interface
- NUM_DIGITS, 6, number of digits driven (1–16)
- CLK_HZ, 50_000_000, clk frequency in Hz
- BLINK_HZ, 2, full blink cycles per second; half-period = CLK_HZ/(2*BLINK_HZ) cycles, must be ≥1
- SCROLL_DIV, 25_000_000, clk cycles per scroll step, ≥1
- ACTIVE_LOW, 1, 1 inverts all segment outputs (DE-series boards)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe, one digit per cycle
- wr_digit  in  $clog2(NUM_DIGITS) (min 1)  target digit index
- wr_data  in  8  hex mode: [3:0] nibble, [7] decimal point; raw mode: [6:0]=g..a, [7]=dp
- wr_raw  in  1  1 = raw segments, 0 = hex decode
- blink_mask  in  NUM_DIGITS  per-digit blink enable
- scroll_en  in  1  level; rotates digit contents while high
- seg_out  out  8*NUM_DIGITS  digit i on [8i+7:8i]; bit0=a … bit6=g, bit7=dp, after polarity
- blink_phase  out  1  current blink phase, 1 = visible

## Operation
- Storage: per digit, an 8-bit data register and a 1-bit raw flag. Decoding happens on output, not on write.
- Hex decode (a..g): 0→3F 1→06 2→5B 3→4F 4→66 5→6D 6→7D 7→07 8→7F 9→6F A→77 b→7C C→39 d→5E E→79 F→71. dp = wr_data[7].
- Write: if wr_en and wr_digit < NUM_DIGITS, the digit registers take wr_data and wr_raw. Out-of-range index: write ignored, no state change.
- Blink: a prescaler counts 0..HALF-1. At wrap, blink_phase toggles. While blink_phase=0, digits with blink_mask[i]=1 are forced to all segments off, dp included.
- Scroll: while scroll_en=1, a step counter counts 0..SCROLL_DIV-1. At wrap, all digits rotate up one position, data and raw flag together: digit i → i+1, digit NUM_DIGITS-1 → digit 0. When scroll_en=0, the counter is held at 0.
- Write and scroll step in the same cycle: rotation applies first, then the write overwrites the post-rotation content of wr_digit.
- blink_mask is not rotated. It is positional.
- Polarity: if ACTIVE_LOW, seg_out = ~segments, so "off" = 8'hFF. Otherwise "off" = 8'h00.

## Timing
- seg_out is fully registered. A write in cycle N is visible on seg_out in cycle N+1.
- A blink_phase change at edge N is reflected on seg_out at edge N+1. A blink_mask change has the same 1-cycle latency.
- First scroll step occurs SCROLL_DIV cycles after scroll_en rises. Later steps follow every SCROLL_DIV cycles.
- Reset (synchronous, any cycle, mid-scroll/mid-blink included):
  - data = 0, raw = 1, so every digit is blank.
  - Both counters = 0.
  - blink_phase = 1.
  - seg_out = all off on the next edge: 8'hFF per digit when ACTIVE_LOW.
- Reset has priority over wr_en and scroll.
- No handshake; writes are accepted every cycle.

## Configuration
- SEVEN_SEG_BLINK_EN defined: blink prescaler and masking are compiled in, as described above.
- SEVEN_SEG_BLINK_EN undefined:
  - Prescaler is removed.
  - blink_phase is tied to 1.
  - blink_mask is ignored.
  - BLINK_HZ is unused.

## Test plan
Benches use NUM_DIGITS=4, CLK_HZ=8, BLINK_HZ=1 (half-period 4), SCROLL_DIV=3, ACTIVE_LOW=1.
- Reset: pulse reset for 1 cycle → next cycle seg_out=32'hFFFF_FFFF, blink_phase=1.
- Hex write: digit 0 ← 8'h0A (hex), digit 1 ← 8'h80 (hex, dp) → one cycle later seg_out[7:0]=8'h88 (~77), seg_out[15:8]=8'h40 (~BF). Write to wr_digit=3 with wr_raw=1, data 8'h49 → seg_out[31:24]=8'hB6.
- Blink (macro defined): digit 0 = 0x3 hex, blink_mask=4'b0001 → seg_out[7:0] alternates 8'hB0 / 8'hFF every 4 cycles; other digits unaffected. With macro undefined → constant 8'hB0.
- Scroll: digits = {3,2,1,0} hex, scroll_en=1 → after 3 cycles digit0 shows 3 (8'hB0) and digit1 shows 0 (8'hC0); after 12 cycles the original order returns.
- Collision and range:
  - Scroll step coincides with a write of 8'h0F to digit 0 → digit 0 = F (8'h8E); digit 1 holds the rotated old digit 0.
  - Write with wr_digit out of range is ignored; seg_out is unchanged. With NUM_DIGITS=4 and a 2-bit index no out-of-range value exists, so this check runs with NUM_DIGITS=6 and wr_digit=6 or 7.
- Reset mid-scroll and mid-blink → all outputs blank next cycle, and scroll restarts its full 3-cycle interval.

Source files
------------

// File: rtl/seven_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_display_ctrl
// Brief    : Registered N-digit seven-segment driver with hex decode or raw
//            segments per digit, positional blinking and rotate-scrolling.
//            Blinking is compiled in only when SEVEN_SEG_BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int SCROLL_DIV = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                wr_en,
    input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] wr_digit,
    input  logic [7:0]                                          wr_data,
    input  logic                                                wr_raw,
    input  logic [NUM_DIGITS-1:0]                               blink_mask,
    input  logic                                                scroll_en,
    output logic [8*NUM_DIGITS-1:0]                             seg_out,
    output logic                                                blink_phase
);

    localparam int                  c_scroll_w    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [c_scroll_w-1:0] c_scroll_last = c_scroll_w'(SCROLL_DIV - 1);
    localparam logic [7:0]          c_pol         = {8{ACTIVE_LOW}};

    logic [7:0]              data_q [NUM_DIGITS];
    logic [7:0]              data_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   raw_q, raw_d;
    logic [c_scroll_w-1:0]   scroll_cnt_q, scroll_cnt_d;
    logic [8*NUM_DIGITS-1:0] seg_out_q, seg_out_d;
    logic                    w_scroll_step;
    logic                    w_wr_ok;
    logic                    w_phase;
    logic [NUM_DIGITS-1:0]   w_mask;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] digit_segs(input logic [7:0] data, input logic raw);
        digit_segs = {data[7], (raw ? data[6:0] : hex7(data[3:0]))};
    endfunction

`ifdef SEVEN_SEG_BLINK_EN
    localparam int                   c_half       = CLK_HZ / (2 * BLINK_HZ);
    localparam int                   c_blink_w    = (c_half > 1) ? $clog2(c_half) : 1;
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(c_half - 1);

    logic [c_blink_w-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q + c_blink_w'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign w_phase = blink_phase_q;
    assign w_mask  = blink_mask;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^{blink_mask, 32'(CLK_HZ), 32'(BLINK_HZ)};
    assign w_phase        = 1'b1;
    assign w_mask         = '0;
`endif

    always_comb begin
        w_scroll_step = 1'b0;
        scroll_cnt_d  = '0;
        if (scroll_en) begin
            if (scroll_cnt_q == c_scroll_last) begin
                w_scroll_step = 1'b1;
            end else begin
                scroll_cnt_d = scroll_cnt_q + c_scroll_w'(1);
            end
        end
    end

    assign w_wr_ok = wr_en && (32'(wr_digit) < NUM_DIGITS);

    // Rotation first, then the write lands on the post-rotation slot.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            data_d[i] = data_q[i];
            raw_d[i]  = raw_q[i];
            if (w_scroll_step) begin
                data_d[i] = data_q[(i + NUM_DIGITS - 1) % NUM_DIGITS];
                raw_d[i]  = raw_q[(i + NUM_DIGITS - 1) % NUM_DIGITS];
            end
            if (w_wr_ok && (32'(wr_digit) == i)) begin
                data_d[i] = wr_data;
                raw_d[i]  = wr_raw;
            end
        end
    end

    // Decoded from next-state contents so a write shows one cycle later;
    // blink uses the current phase so a phase change lags by one edge.
    always_comb begin
        seg_out_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_out_d[8*i +: 8] = c_pol ^ ((!w_phase && w_mask[i]) ? 8'h00
                                           : digit_segs(data_d[i], raw_d[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                data_q[i] <= '0;
            end
            raw_q        <= '1;
            scroll_cnt_q <= '0;
            seg_out_q    <= {NUM_DIGITS{c_pol}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                data_q[i] <= data_d[i];
            end
            raw_q        <= raw_d;
            scroll_cnt_q <= scroll_cnt_d;
            seg_out_q    <= seg_out_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign blink_phase = w_phase;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_display_ctrl
// Brief    : Self-checking bench: 4-digit instance for decode, blink, scroll
//            and reset; 6-digit instance for out-of-range write indices.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_display_ctrl;

`ifdef SEVEN_SEG_BLINK_EN
    localparam bit c_blink_on = 1'b1;
`else
    localparam bit c_blink_on = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        a_wr_en, a_wr_raw, a_scroll, a_phase;
    logic [1:0]  a_wr_digit;
    logic [7:0]  a_wr_data;
    logic [3:0]  a_mask;
    logic [31:0] a_seg;

    logic        b_wr_en, b_wr_raw, b_scroll, b_phase;
    logic [2:0]  b_wr_digit;
    logic [7:0]  b_wr_data;
    logic [5:0]  b_mask;
    logic [47:0] b_seg;

    always #5 clk = ~clk;

    seven_seg_display_ctrl #(
        .NUM_DIGITS(4), .CLK_HZ(8), .BLINK_HZ(1), .SCROLL_DIV(3), .ACTIVE_LOW(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_digit(a_wr_digit),
        .wr_data(a_wr_data), .wr_raw(a_wr_raw), .blink_mask(a_mask),
        .scroll_en(a_scroll), .seg_out(a_seg), .blink_phase(a_phase)
    );

    seven_seg_display_ctrl #(
        .NUM_DIGITS(6), .CLK_HZ(8), .BLINK_HZ(1), .SCROLL_DIV(3), .ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_digit(b_wr_digit),
        .wr_data(b_wr_data), .wr_raw(b_wr_raw), .blink_mask(b_mask),
        .scroll_en(b_scroll), .seg_out(b_seg), .blink_phase(b_phase)
    );

    typedef struct {
        string       name;
        logic        sel_b;
        logic [47:0] exp_seg;
        logic        chk_phase;
        logic        exp_phase;
    } sb_t;

    typedef struct {
        logic        we;
        logic [1:0]  dig;
        logic [7:0]  data;
        logic        raw;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0]  hex_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [31:0] load_exp [4]   = '{32'hFFFF_FFC0, 32'hFFFF_F9C0, 32'hFFA4_F9C0, 32'hB0A4_F9C0};
    logic [31:0] scroll_exp [4] = '{32'hB0A4_F9C0, 32'hA4F9_C0B0, 32'hF9C0_B0A4, 32'hC0B0_A4F9};

    function automatic void expect_seg(input string name, input logic sel_b,
                                       input logic [47:0] exp, input logic chk_ph,
                                       input logic exp_ph);
        sb_t e;
        e.name      = name;
        e.sel_b     = sel_b;
        e.exp_seg   = exp;
        e.chk_phase = chk_ph;
        e.exp_phase = exp_ph;
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        sb_t         e;
        logic [47:0] got;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = e.sel_b ? b_seg : {16'h0000, a_seg};
            checks++;
            if (got !== e.exp_seg) begin
                errors++;
                $display("FAIL %s: seg_out=%h expected %h", e.name, got, e.exp_seg);
            end
            if (e.chk_phase) begin
                checks++;
                if (a_phase !== e.exp_phase) begin
                    errors++;
                    $display("FAIL %s phase: blink_phase=%b expected %b", e.name, a_phase, e.exp_phase);
                end
            end
        end
    endtask

    // Reset cycle also carries a write to prove reset wins.
    task automatic do_reset(input string name);
        reset      = 1'b1;
        a_wr_en    = 1'b1; a_wr_digit = 2'd0; a_wr_data = 8'h08; a_wr_raw = 1'b0;
        b_wr_en    = 1'b1; b_wr_digit = 3'd0; b_wr_data = 8'h08; b_wr_raw = 1'b0;
        expect_seg(name, 1'b0, 48'h0000_FFFF_FFFF, 1'b1, 1'b1);
        expect_seg({name, "_b"}, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
        tick();
        reset   = 1'b0;
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic blink_run(input string name, input int n);
        logic [7:0] d0, d1;
        logic       vis, ph;
        do_reset({name, "_reset"});
        for (int k = 1; k <= n; k++) begin
            a_mask     = 4'b0001;
            a_wr_en    = (k <= 2);
            a_wr_digit = (k == 1) ? 2'd0 : 2'd1;
            a_wr_data  = (k == 1) ? 8'h03 : 8'h01;
            a_wr_raw   = 1'b0;
            vis = c_blink_on ? ((((k - 1) / 4) % 2) == 0) : 1'b1;
            ph  = c_blink_on ? (((k / 4) % 2) == 0) : 1'b1;
            d0  = vis ? 8'hB0 : 8'hFF;
            d1  = (k >= 2) ? 8'hF9 : 8'hFF;
            expect_seg($sformatf("%s k=%0d", name, k), 1'b0, {16'h0000, 16'hFFFF, d1, d0}, 1'b1, ph);
            tick();
        end
        a_wr_en = 1'b0;
        a_mask  = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_wr_en = 0; a_wr_digit = 0; a_wr_data = 0; a_wr_raw = 0; a_mask = 0; a_scroll = 0;
        b_wr_en = 0; b_wr_digit = 0; b_wr_data = 0; b_wr_raw = 0; b_mask = 0; b_scroll = 0;

        do_reset("reset");

        tbl.push_back('{1'b1, 2'd0, 8'h0A, 1'b0, 32'hFFFF_FF88});
        tbl.push_back('{1'b1, 2'd1, 8'h80, 1'b0, 32'hFFFF_4088});
        tbl.push_back('{1'b1, 2'd3, 8'h49, 1'b1, 32'hB6FF_4088});
        tbl.push_back('{1'b1, 2'd2, 8'h05, 1'b0, 32'hB692_4088});
        tbl.push_back('{1'b0, 2'd2, 8'h00, 1'b0, 32'hB692_4088});
        tbl.push_back('{1'b1, 2'd2, 8'h00, 1'b1, 32'hB6FF_4088});
        tbl.push_back('{1'b1, 2'd0, 8'h8C, 1'b0, 32'hB6FF_4046});
        for (int v = 0; v < 16; v++) begin
            tbl.push_back('{1'b1, 2'd0, 8'(v), 1'b0, {24'hB6FF40, ~{1'b0, hex_seg[v]}}});
        end
        for (int i = 0; i < tbl.size(); i++) begin
            a_wr_en    = tbl[i].we;
            a_wr_digit = tbl[i].dig;
            a_wr_data  = tbl[i].data;
            a_wr_raw   = tbl[i].raw;
            expect_seg($sformatf("vec%0d", i), 1'b0, {16'h0000, tbl[i].exp}, 1'b0, 1'b0);
            tick();
        end
        a_wr_en = 1'b0;

        blink_run("blink1", 14);
        blink_run("blink2", 9);

        do_reset("scroll_reset");
        for (int d = 0; d < 4; d++) begin
            a_wr_en = 1'b1; a_wr_digit = 2'(d); a_wr_data = 8'(d); a_wr_raw = 1'b0;
            expect_seg($sformatf("load d%0d", d), 1'b0, {16'h0000, load_exp[d]}, 1'b0, 1'b0);
            tick();
        end
        a_wr_en  = 1'b0;
        a_scroll = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            expect_seg($sformatf("scroll k=%0d", k), 1'b0, {16'h0000, scroll_exp[(k / 3) % 4]}, 1'b0, 1'b0);
            tick();
        end
        a_wr_en = 1'b1; a_wr_digit = 2'd0; a_wr_data = 8'h0F; a_wr_raw = 1'b0;
        expect_seg("collision", 1'b0, 48'h0000_A4F9_C08E, 1'b0, 1'b0);
        tick();
        a_wr_en = 1'b0;
        expect_seg("collision hold", 1'b0, 48'h0000_A4F9_C08E, 1'b0, 1'b0);
        tick();

        do_reset("reset midscroll");
        a_wr_en = 1'b1; a_wr_digit = 2'd0; a_wr_data = 8'h03; a_wr_raw = 1'b0;
        expect_seg("restart q1", 1'b0, 48'h0000_FFFF_FFB0, 1'b0, 1'b0);
        tick();
        a_wr_en = 1'b0;
        expect_seg("restart q2", 1'b0, 48'h0000_FFFF_FFB0, 1'b0, 1'b0);
        tick();
        expect_seg("restart q3", 1'b0, 48'h0000_FFFF_B0FF, 1'b0, 1'b0);
        tick();
        expect_seg("restart q4", 1'b0, 48'h0000_FFFF_B0FF, 1'b0, 1'b0);
        tick();
        a_scroll = 1'b0;

        do_reset("oor_reset");
        b_wr_en = 1'b1; b_wr_raw = 1'b0;
        b_wr_digit = 3'd5; b_wr_data = 8'h0A;
        expect_seg("b wr5", 1'b1, 48'h88FF_FFFF_FFFF, 1'b0, 1'b0);
        tick();
        b_wr_digit = 3'd0; b_wr_data = 8'h01;
        expect_seg("b wr0", 1'b1, 48'h88FF_FFFF_FFF9, 1'b0, 1'b0);
        tick();
        b_wr_digit = 3'd6; b_wr_data = 8'h08;
        expect_seg("b oor6", 1'b1, 48'h88FF_FFFF_FFF9, 1'b0, 1'b0);
        tick();
        b_wr_digit = 3'd7; b_wr_data = 8'h08; b_wr_raw = 1'b1;
        expect_seg("b oor7", 1'b1, 48'h88FF_FFFF_FFF9, 1'b0, 1'b0);
        tick();
        b_wr_digit = 3'd4; b_wr_data = 8'h08; b_wr_raw = 1'b0;
        expect_seg("b wr4", 1'b1, 48'h8880_FFFF_FFF9, 1'b0, 1'b0);
        tick();
        b_wr_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
